debug_controller: RTL and testbench

- CPU-clock-domain consumer of the JTAG debug bridge outputs.
- Turns the seize level into an instruction-boundary stall and reports the stopped state back to the bridge.
- Executes 8-bit debug procedure codes against the register file and memory bus, and returns a 16-bit result.
- Sits between the bridge's CDC outputs and the CPU core / memory arbiter.

---
 rtl/debug_controller_if.sv | 41 ++++
 rtl/debug_controller.sv | 131 +++++++++++++
 tb/tb_debug_controller.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_controller_if.sv
// Purpose: groups every debug_controller signal except clk/reset into one bundle.
// Latency: no logic here; wires only.
// Backpressure: none in the bundle. The memory side waits on mem_ack.
// Ports: bridge side (seize/run/addr/wr_*/stopped/val), CPU side (cpu_stall/cpu_at_boundary),
//        register file side (reg_*), memory arbiter side (mem_*).
//        The slave modport is the controller's view. The master modport is the environment's view.
interface debug_controller_if;
  logic        debug_seize;
  logic        debug_run;
  logic [7:0]  debug_addr;
  logic [15:0] debug_wr_val;
  logic        debug_wr_en;
  logic        debug_stopped;
  logic [15:0] debug_val;
  logic        cpu_stall;
  logic        cpu_at_boundary;
  logic [3:0]  reg_sel;
  logic [15:0] reg_rd_val;
  logic [15:0] reg_wr_val;
  logic        reg_wr_en;
  logic        mem_access;
  logic        mem_ack;
  logic        mem_wr_en;
  logic [18:0] mem_addr;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;

  modport slave (
    input  debug_seize, debug_run, debug_addr, debug_wr_val, debug_wr_en,
    input  cpu_at_boundary, reg_rd_val, mem_ack, mem_data_in,
    output debug_stopped, debug_val, cpu_stall, reg_sel, reg_wr_val, reg_wr_en,
    output mem_access, mem_wr_en, mem_addr, mem_data_out
  );

  modport master (
    output debug_seize, debug_run, debug_addr, debug_wr_val, debug_wr_en,
    output cpu_at_boundary, reg_rd_val, mem_ack, mem_data_in,
    input  debug_stopped, debug_val, cpu_stall, reg_sel, reg_wr_val, reg_wr_en,
    input  mem_access, mem_wr_en, mem_addr, mem_data_out
  );
endinterface

// File: rtl/debug_controller.sv
// Purpose: stalls the CPU on seize and runs 8-bit debug procedures against the regfile and memory.
// Latency: run->stopped is 4 cycles for a reg read and 3 for reg write/seg/off/status. Memory takes 3 plus the ack wait.
// Backpressure: a memory procedure holds its request stable until mem_ack. debug_run is honoured only in STOPPED.
// Ports: clk, reset (async, active high), dbg (debug_controller_if.slave: bridge, CPU, regfile and memory signals).
module debug_controller #(
  parameter logic [15:0] ILLEGAL_VAL = 16'hffff
) (
  input logic           clk,
  input logic           reset,
  debug_controller_if.slave dbg
);

  typedef enum logic [2:0] {
    RUNNING, SEIZING, STOPPED, REG_RD, REG_CAP, REG_WR, MEM, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  op;
  logic [15:0] wr_latch, wr_latch_nxt;
  logic [15:0] mem_seg, mem_off;
  logic [15:0] debug_val_q;
  logic [18:0] mem_addr_q;
  logic [15:0] mem_data_q;
  logic        mem_wr_q;
  logic [18:0] mem_word;
  logic        start;

  // A write arriving together with debug_run must be seen by that procedure.
  assign wr_latch_nxt = dbg.debug_wr_en ? dbg.debug_wr_val : wr_latch;
  assign start        = (state == STOPPED) && dbg.debug_run;

  // Compute the word address directly.
  // seg*16 is even, so (seg*16 + off) >> 1 equals seg*8 + (off >> 1), taken modulo 2^19.
  assign mem_word = {mem_seg, 3'b000} + {4'b0000, mem_off[15:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUNNING;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUNNING: if (dbg.debug_seize) state_nxt = SEIZING;
      SEIZING: begin
        if (!dbg.debug_seize)          state_nxt = RUNNING;
        else if (dbg.cpu_at_boundary)  state_nxt = STOPPED;
      end
      STOPPED: begin
        if (dbg.debug_run) begin
          if (dbg.debug_addr[7:4] == 4'h0)      state_nxt = REG_RD;
          else if (dbg.debug_addr[7:4] == 4'h1) state_nxt = REG_WR;
          else if (dbg.debug_addr == 8'h22 || dbg.debug_addr == 8'h23) state_nxt = MEM;
          // seg/off/status/illegal codes produce their result in REG_CAP.
          else                                  state_nxt = REG_CAP;
        end else if (!dbg.debug_seize) begin
          state_nxt = RUNNING;
        end
      end
      REG_RD:  state_nxt = REG_CAP;
      REG_CAP: state_nxt = DONE;
      REG_WR:  state_nxt = DONE;
      MEM:     if (dbg.mem_ack) state_nxt = DONE;
      DONE:    state_nxt = STOPPED;
      default: state_nxt = RUNNING;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op          <= 8'h00;
      wr_latch    <= 16'h0000;
      mem_seg     <= 16'h0000;
      mem_off     <= 16'h0000;
      debug_val_q <= 16'h0000;
      mem_addr_q  <= 19'h00000;
      mem_data_q  <= 16'h0000;
      mem_wr_q    <= 1'b0;
    end else begin
      wr_latch <= wr_latch_nxt;
      if (start) begin
        op         <= dbg.debug_addr;
        // Freeze the memory request so it cannot move while waiting for ack.
        mem_addr_q <= mem_word;
        mem_data_q <= wr_latch_nxt;
        mem_wr_q   <= (dbg.debug_addr == 8'h23);
      end
      case (state)
        REG_WR: debug_val_q <= wr_latch;
        REG_CAP: begin
          if (op[7:4] == 4'h0) begin
            debug_val_q <= dbg.reg_rd_val;
          end else begin
            case (op)
              8'h20: begin
                mem_seg     <= wr_latch;
                debug_val_q <= wr_latch;
              end
              8'h21: begin
                mem_off     <= wr_latch;
                debug_val_q <= wr_latch;
              end
              8'h24:   debug_val_q <= mem_seg;
              8'h25:   debug_val_q <= mem_off;
              default: debug_val_q <= ILLEGAL_VAL;
            endcase
          end
        end
        MEM: begin
          if (dbg.mem_ack) begin
            debug_val_q <= mem_wr_q ? mem_data_q : dbg.mem_data_in;
            mem_off     <= mem_off + 16'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg.cpu_stall     = (state != RUNNING);
  assign dbg.debug_stopped = (state == STOPPED);
  assign dbg.debug_val     = debug_val_q;
  assign dbg.reg_sel       = (state == REG_RD || state == REG_CAP || state == REG_WR) ? op[3:0] : 4'h0;
  assign dbg.reg_wr_en     = (state == REG_WR);
  assign dbg.reg_wr_val    = (state == REG_WR) ? wr_latch : 16'h0000;
  assign dbg.mem_access    = (state == MEM);
  assign dbg.mem_wr_en     = (state == MEM) && mem_wr_q;
  assign dbg.mem_addr      = (state == MEM) ? mem_addr_q : 19'h00000;
  assign dbg.mem_data_out  = (state == MEM) ? mem_data_q : 16'h0000;

endmodule

// File: tb/tb_debug_controller.sv
module tb_debug_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_controller_if dbg_if ();
  debug_controller #(.ILLEGAL_VAL(16'hffff)) dut (.clk(clk), .reset(reset), .dbg(dbg_if));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] m_seg, m_off, m_latch;
  logic [15:0] m_regs [16];
  // Environment register file that responds to the DUT
  logic [15:0] env_regs [16];

  typedef struct {
    int lat; int nwr; logic [3:0] sel; logic [15:0] wval; int macc;
    logic [18:0] maddr; logic mwr; logic [15:0] mdat; bit stable; logic [15:0] dval;
  } res_t;

  typedef struct {
    int lat; int nwr; logic [3:0] sel; logic [15:0] wval; int macc;
    logic [18:0] addr; logic mwr; logic [15:0] mdat; logic [15:0] dval;
  } exp_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_wr(input logic [15:0] v);
    dbg_if.debug_wr_val = v;
    dbg_if.debug_wr_en  = 1'b1;
    tick();
    dbg_if.debug_wr_en  = 1'b0;
    m_latch = v;
  endtask

  task automatic enter_stopped(output int cyc);
    dbg_if.debug_seize     = 1'b1;
    dbg_if.cpu_at_boundary = 1'b1;
    cyc = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dbg_if.debug_stopped) begin
        cyc = i + 1;
        break;
      end
    end
  endtask

  // Behavioural model: applies one procedure code to the abstract debug state.
  task automatic model_proc(input logic [7:0] code, input bit bypass, input logic [15:0] wv,
                            input int dly, input logic [15:0] mdin, output exp_t e);
    int phys;
    if (bypass) m_latch = wv;
    e.lat = 0; e.nwr = 0; e.macc = 0; e.addr = '0; e.mwr = 1'b0; e.mdat = '0;
    e.sel = code[3:0]; e.wval = '0; e.dval = '0;
    if (code < 8'h10) begin
      e.dval = m_regs[code[3:0]];
      e.lat  = 4;
    end else if (code < 8'h20) begin
      m_regs[code[3:0]] = m_latch;
      e.nwr = 1; e.wval = m_latch; e.dval = m_latch; e.lat = 3;
    end else begin
      case (code)
        8'h20: begin m_seg = m_latch; e.dval = m_latch; e.lat = 3; end
        8'h21: begin m_off = m_latch; e.dval = m_latch; e.lat = 3; end
        8'h22, 8'h23: begin
          phys   = (int'(m_seg) * 16 + int'(m_off)) % (1 << 20);
          e.addr = 19'(phys / 2);
          e.macc = dly + 1;
          e.lat  = 3 + dly;
          e.mwr  = (code == 8'h23);
          e.mdat = m_latch;
          e.dval = (code == 8'h22) ? mdin : m_latch;
          m_off  = 16'((int'(m_off) + 2) % 65536);
        end
        8'h24: begin e.dval = m_seg; e.lat = 3; end
        8'h25: begin e.dval = m_off; e.lat = 3; end
        default: e.dval = 16'hffff;
      endcase
    end
  endtask

  // Drives one procedure from STOPPED and records what the DUT did until it stops again.
  task automatic run_proc(input logic [7:0] code, input bit bypass, input logic [15:0] wv,
                          input int dly, input logic [15:0] mdin, output res_t r);
    int wcnt = 0;
    logic [3:0] prev_sel = 4'h0;
    r.lat = -1; r.nwr = 0; r.sel = '0; r.wval = '0; r.macc = 0; r.maddr = '0;
    r.mwr = 1'b0; r.mdat = '0; r.stable = 1'b1; r.dval = '0;
    dbg_if.debug_addr = code;
    dbg_if.debug_run  = 1'b1;
    if (bypass) begin
      dbg_if.debug_wr_val = wv;
      dbg_if.debug_wr_en  = 1'b1;
    end
    tick();
    dbg_if.debug_run   = 1'b0;
    dbg_if.debug_wr_en = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      dbg_if.mem_ack     = 1'b0;
      dbg_if.mem_data_in = ~mdin;
      // Read data follows reg_sel with one cycle of latency.
      dbg_if.reg_rd_val  = (c >= 2) ? env_regs[prev_sel] : 16'hdead;
      prev_sel = dbg_if.reg_sel;
      if (c == 1) r.sel = dbg_if.reg_sel;
      if (dbg_if.debug_stopped) begin
        r.lat  = c;
        r.dval = dbg_if.debug_val;
        break;
      end
      if (dbg_if.reg_wr_en) begin
        r.nwr++;
        r.wval = dbg_if.reg_wr_val;
        env_regs[dbg_if.reg_sel] = dbg_if.reg_wr_val;
      end
      if (dbg_if.mem_access) begin
        if (r.macc == 0) begin
          r.maddr = dbg_if.mem_addr; r.mwr = dbg_if.mem_wr_en; r.mdat = dbg_if.mem_data_out;
        end else if ({dbg_if.mem_addr, dbg_if.mem_wr_en, dbg_if.mem_data_out} !== {r.maddr, r.mwr, r.mdat}) begin
          r.stable = 1'b0;
        end
        r.macc++;
        if (wcnt == dly) begin
          dbg_if.mem_ack     = 1'b1;
          dbg_if.mem_data_in = mdin;
        end else begin
          wcnt++;
        end
      end
      tick();
    end
    dbg_if.mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({dbg_if.debug_stopped, dbg_if.debug_val, dbg_if.cpu_stall, dbg_if.reg_sel, dbg_if.reg_wr_en,
         dbg_if.reg_wr_val, dbg_if.mem_access, dbg_if.mem_wr_en, dbg_if.mem_addr, dbg_if.mem_data_out} !== '0) begin
      $display("FAIL reset_outputs: got stopped=%b val=%h stall=%b mem_access=%b, want all zero",
               dbg_if.debug_stopped, dbg_if.debug_val, dbg_if.cpu_stall, dbg_if.mem_access);
      miscompares++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_seize;
    int bad = 0;
    // Seize withdrawn before the CPU reaches a boundary
    dbg_if.debug_seize = 1'b1;
    tick();
    vectors++;
    if (dbg_if.cpu_stall !== 1'b1) begin
      $display("FAIL abort_stall_on: got %b want 1", dbg_if.cpu_stall); miscompares++;
    end
    dbg_if.debug_seize = 1'b0;
    tick();
    vectors++;
    if (dbg_if.cpu_stall !== 1'b0) begin
      $display("FAIL abort_stall_off: got %b want 0", dbg_if.cpu_stall); miscompares++;
    end
    // debug_run while running is ignored
    dbg_if.debug_addr = 8'h13;
    dbg_if.debug_run  = 1'b1;
    tick();
    dbg_if.debug_run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dbg_if.reg_wr_en || dbg_if.cpu_stall || dbg_if.mem_access) bad++;
      tick();
    end
    vectors++;
    if (bad != 0) begin
      $display("FAIL run_while_running: got %0d active cycles want 0", bad); miscompares++;
    end
    // Boundary reached five cycles after seize
    dbg_if.debug_seize = 1'b1;
    tick();
    vectors++;
    if ({dbg_if.cpu_stall, dbg_if.debug_stopped} !== 2'b10) begin
      $display("FAIL seize_stall: got stall/stopped=%b want 10", {dbg_if.cpu_stall, dbg_if.debug_stopped});
      miscompares++;
    end
    for (int i = 2; i <= 5; i++) tick();
    dbg_if.cpu_at_boundary = 1'b1;
    tick();
    vectors++;
    if (dbg_if.debug_stopped !== 1'b1) begin
      $display("FAIL seize_stopped: got %b want 1", dbg_if.debug_stopped); miscompares++;
    end
    dbg_if.debug_seize = 1'b0;
    tick();
    vectors++;
    if ({dbg_if.cpu_stall, dbg_if.debug_stopped} !== 2'b00) begin
      $display("FAIL release: got stall/stopped=%b want 00", {dbg_if.cpu_stall, dbg_if.debug_stopped});
      miscompares++;
    end
    dbg_if.cpu_at_boundary = 1'b0;
  endtask

  task automatic test_register;
    res_t r; exp_t e; int cyc;
    enter_stopped(cyc);
    vectors++;
    if (cyc < 0) begin $display("FAIL reg_enter_stopped: got timeout want stopped"); miscompares++; end
    load_wr(16'h1234);
    model_proc(8'h13, 1'b0, 16'h0, 0, 16'h0, e);
    run_proc(8'h13, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if ({r.nwr, r.sel, r.wval} !== {e.nwr, e.sel, e.wval}) begin
      $display("FAIL reg_write: got n=%0d sel=%0d val=%h want n=%0d sel=%0d val=%h", r.nwr, r.sel, r.wval, e.nwr, e.sel, e.wval);
      miscompares++;
    end
    vectors++;
    if (r.lat !== e.lat) begin $display("FAIL reg_write_latency: got %0d want %0d", r.lat, e.lat); miscompares++; end
    model_proc(8'h03, 1'b0, 16'h0, 0, 16'h0, e);
    run_proc(8'h03, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.dval !== e.dval) begin $display("FAIL reg_read_val: got %h want %h", r.dval, e.dval); miscompares++; end
    vectors++;
    if (r.lat !== e.lat) begin $display("FAIL reg_read_latency: got %0d want %0d", r.lat, e.lat); miscompares++; end
  endtask

  task automatic test_memory;
    res_t r; exp_t e; int cyc;
    enter_stopped(cyc);
    load_wr(16'hf000);
    model_proc(8'h20, 1'b0, 16'h0, 0, 16'h0, e); run_proc(8'h20, 1'b0, 16'h0, 0, 16'h0, r);
    load_wr(16'hfffe);
    model_proc(8'h21, 1'b0, 16'h0, 0, 16'h0, e); run_proc(8'h21, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.lat !== e.lat) begin $display("FAIL off_latency: got %0d want %0d", r.lat, e.lat); miscompares++; end
    load_wr(16'habcd);
    model_proc(8'h23, 1'b0, 16'h0, 3, 16'h0, e);
    run_proc(8'h23, 1'b0, 16'h0, 3, 16'h0, r);
    vectors++;
    if ({r.maddr, r.mwr, r.mdat} !== {19'h7ffff, 1'b1, 16'habcd} || {r.maddr, r.mdat} !== {e.addr, e.mdat}) begin
      $display("FAIL mem_write_req: got addr=%h wr=%b data=%h want addr=%h wr=1 data=%h", r.maddr, r.mwr, r.mdat, e.addr, e.mdat);
      miscompares++;
    end
    vectors++;
    if (r.stable !== 1'b1 || r.macc !== e.macc) begin
      $display("FAIL mem_write_hold: got stable=%b cycles=%0d want stable=1 cycles=%0d", r.stable, r.macc, e.macc);
      miscompares++;
    end
    vectors++;
    if (r.lat !== e.lat) begin $display("FAIL mem_write_latency: got %0d want %0d", r.lat, e.lat); miscompares++; end
    model_proc(8'h22, 1'b0, 16'h0, 0, 16'h5a5a, e);
    run_proc(8'h22, 1'b0, 16'h0, 0, 16'h5a5a, r);
    vectors++;
    if ({r.dval, r.maddr, r.mwr} !== {16'h5a5a, 19'h78000, 1'b0}) begin
      $display("FAIL mem_read: got val=%h addr=%h wr=%b want val=5a5a addr=78000 wr=0", r.dval, r.maddr, r.mwr);
      miscompares++;
    end
    model_proc(8'h25, 1'b0, 16'h0, 0, 16'h0, e); run_proc(8'h25, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.dval !== e.dval) begin $display("FAIL mem_off_incr: got %h want %h", r.dval, e.dval); miscompares++; end
  endtask

  task automatic test_illegal;
    res_t r; exp_t e;
    model_proc(8'h80, 1'b0, 16'h0, 0, 16'h0, e);
    run_proc(8'h80, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if ({r.dval, r.nwr, r.macc} !== {e.dval, 32'd0, 32'd0} || r.lat < 0) begin
      $display("FAIL illegal_code: got val=%h wr=%0d mem=%0d lat=%0d want val=ffff wr=0 mem=0", r.dval, r.nwr, r.macc, r.lat);
      miscompares++;
    end
  endtask

  task automatic test_bypass;
    res_t r; exp_t e;
    model_proc(8'h21, 1'b1, 16'h00ff, 0, 16'h0, e);
    run_proc(8'h21, 1'b1, 16'h00ff, 0, 16'h0, r);
    model_proc(8'h25, 1'b0, 16'h0, 0, 16'h0, e);
    run_proc(8'h25, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.dval !== 16'h00ff || e.dval !== 16'h00ff) begin
      $display("FAIL bypass_off: got %h model %h want 00ff", r.dval, e.dval); miscompares++;
    end
  endtask

  task automatic test_seize_drop;
    res_t r; exp_t e; int cyc;
    enter_stopped(cyc);
    dbg_if.debug_seize = 1'b0;
    model_proc(8'h24, 1'b0, 16'h0, 0, 16'h0, e);
    run_proc(8'h24, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.lat !== e.lat || r.dval !== e.dval) begin
      $display("FAIL drop_completes: got lat=%0d val=%h want lat=%0d val=%h", r.lat, r.dval, e.lat, e.dval); miscompares++;
    end
    tick();
    vectors++;
    if ({dbg_if.debug_stopped, dbg_if.cpu_stall} !== 2'b00) begin
      $display("FAIL drop_resume: got stopped/stall=%b want 00", {dbg_if.debug_stopped, dbg_if.cpu_stall}); miscompares++;
    end
  endtask

  task automatic test_random;
    res_t r; exp_t e; int cyc;
    logic [7:0] code; logic [15:0] wv, md; bit bp; int dly;
    enter_stopped(cyc);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    code = 8'($urandom_range(0, 15));
        2, 3:    code = 8'($urandom_range(16, 31));
        4:       code = 8'h20;
        5:       code = 8'h21;
        6:       code = 8'h22;
        7:       code = 8'h23;
        8:       code = ($urandom_range(0, 1) == 1) ? 8'h24 : 8'h25;
        default: code = 8'($urandom_range(38, 255));
      endcase
      wv  = 16'($urandom);
      md  = 16'($urandom);
      bp  = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 4);
      if (!bp) load_wr(wv);
      model_proc(code, bp, wv, dly, md, e);
      run_proc(code, bp, wv, dly, md, r);
      vectors++;
      if (r.dval !== e.dval) begin
        $display("FAIL rnd_val code=%h: got %h want %h", code, r.dval, e.dval); miscompares++;
      end
      vectors++;
      if ((e.lat != 0 && r.lat != e.lat) || r.lat < 0) begin
        $display("FAIL rnd_latency code=%h: got %0d want %0d", code, r.lat, e.lat); miscompares++;
      end
      vectors++;
      if (r.nwr != e.nwr || r.macc != e.macc) begin
        $display("FAIL rnd_side_effects code=%h: got wr=%0d mem=%0d want wr=%0d mem=%0d", code, r.nwr, r.macc, e.nwr, e.macc);
        miscompares++;
      end
      if (e.macc > 0) begin
        vectors++;
        if ({r.maddr, r.mwr, r.stable} !== {e.addr, e.mwr, 1'b1} || (e.mwr && r.mdat !== e.mdat)) begin
          $display("FAIL rnd_mem code=%h: got addr=%h wr=%b data=%h stable=%b want addr=%h wr=%b data=%h",
                   code, r.maddr, r.mwr, r.mdat, r.stable, e.addr, e.mwr, e.mdat);
          miscompares++;
        end
      end
      if (code < 8'h20) begin
        vectors++;
        if (r.sel !== e.sel || (e.nwr == 1 && r.wval !== e.wval)) begin
          $display("FAIL rnd_reg code=%h: got sel=%0d val=%h want sel=%0d val=%h", code, r.sel, r.wval, e.sel, e.wval);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_mem;
    res_t r; exp_t e; int cyc;
    enter_stopped(cyc);
    load_wr(16'h4321);
    dbg_if.debug_addr = 8'h23;
    dbg_if.debug_run  = 1'b1;
    tick();
    dbg_if.debug_run = 1'b0;
    tick();
    vectors++;
    if (dbg_if.mem_access !== 1'b1) begin
      $display("FAIL mid_mem_wait: got mem_access=%b want 1", dbg_if.mem_access); miscompares++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({dbg_if.mem_access, dbg_if.debug_stopped, dbg_if.cpu_stall, dbg_if.mem_wr_en} !== 4'b0000) begin
      $display("FAIL async_reset: got access/stopped/stall/wr=%b want 0000",
               {dbg_if.mem_access, dbg_if.debug_stopped, dbg_if.cpu_stall, dbg_if.mem_wr_en});
      miscompares++;
    end
    tick();
    reset = 1'b0;
    m_seg = '0; m_off = '0; m_latch = '0;
    enter_stopped(cyc);
    vectors++;
    if (dbg_if.debug_val !== 16'h0000) begin
      $display("FAIL reset_val: got %h want 0000", dbg_if.debug_val); miscompares++;
    end
    model_proc(8'h24, 1'b0, 16'h0, 0, 16'h0, e); run_proc(8'h24, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.dval !== e.dval) begin $display("FAIL reset_seg: got %h want %h", r.dval, e.dval); miscompares++; end
    model_proc(8'h25, 1'b0, 16'h0, 0, 16'h0, e); run_proc(8'h25, 1'b0, 16'h0, 0, 16'h0, r);
    vectors++;
    if (r.dval !== e.dval) begin $display("FAIL reset_off: got %h want %h", r.dval, e.dval); miscompares++; end
  endtask

  initial begin
    reset = 1'b1;
    dbg_if.debug_seize = 1'b0; dbg_if.debug_run = 1'b0; dbg_if.debug_addr = '0;
    dbg_if.debug_wr_val = '0; dbg_if.debug_wr_en = 1'b0; dbg_if.cpu_at_boundary = 1'b0;
    dbg_if.reg_rd_val = '0; dbg_if.mem_ack = 1'b0; dbg_if.mem_data_in = '0;
    m_seg = '0; m_off = '0; m_latch = '0;
    for (int i = 0; i < 16; i++) begin
      env_regs[i] = 16'($urandom);
      m_regs[i]   = env_regs[i];
    end
    test_reset();
    test_seize();
    test_register();
    test_memory();
    test_illegal();
    test_bypass();
    test_seize_drop();
    test_random();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
